// File: rtl/mem_access_ctrl.sv
// Burst initiator for an 8-bit async SRAM-style memory: valid/ready bursts in, one chip_en strobe per beat out.
// Optional write-verify read-back beat is enabled by defining MEM_ACC_WRITE_VERIFY_EN.
module mem_access_ctrl #(
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int LENW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [LENW-1:0] req_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DW-1:0]   wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DW-1:0]   rd_data,
  output logic            busy,
  output logic            done,
  output logic            verify_err,
  output logic [AW-1:0]   mem_address,
  output logic [DW-1:0]   mem_data_in,
  input  logic [DW-1:0]   mem_data_out,
  output logic            mem_read_write,
  output logic            mem_chip_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_WAIT,
    S_WR_STROBE,
    S_RD_STROBE,
    S_RD_HOLD,
    S_DONE
`ifdef MEM_ACC_WRITE_VERIFY_EN
    , S_VF_STROBE
`endif
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [LENW-1:0] cnt;
  logic [AW-1:0]   addr;
  logic            advance;
  logic            last_beat;
  logic            strobe_next;
  logic            write_next;

  assign last_beat   = (cnt == '0);
  assign mem_address = addr;

  assign req_ready = (state == S_IDLE);
  assign wr_ready  = (state == S_WR_WAIT);
  assign rd_valid  = (state == S_RD_HOLD);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // advance marks the point where a beat is fully retired and the burst moves on
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) next_state = req_write ? S_WR_WAIT : S_RD_STROBE;
      end
      S_WR_WAIT: begin
        if (wr_valid) next_state = S_WR_STROBE;
      end
      S_WR_STROBE: begin
`ifdef MEM_ACC_WRITE_VERIFY_EN
        next_state = S_VF_STROBE;
`else
        advance    = 1'b1;
        next_state = last_beat ? S_DONE : S_WR_WAIT;
`endif
      end
`ifdef MEM_ACC_WRITE_VERIFY_EN
      S_VF_STROBE: begin
        advance    = 1'b1;
        next_state = last_beat ? S_DONE : S_WR_WAIT;
      end
`endif
      S_RD_STROBE: next_state = S_RD_HOLD;
      S_RD_HOLD: begin
        if (rd_ready) begin
          advance    = 1'b1;
          next_state = last_beat ? S_DONE : S_RD_STROBE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Strobe controls are registered from the next state so they line up exactly with the strobe states
  always_comb begin
    strobe_next = (next_state == S_WR_STROBE) || (next_state == S_RD_STROBE);
`ifdef MEM_ACC_WRITE_VERIFY_EN
    strobe_next = strobe_next || (next_state == S_VF_STROBE);
`endif
    write_next = (next_state == S_WR_STROBE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      addr           <= '0;
      mem_data_in    <= '0;
      mem_read_write <= 1'b0;
      mem_chip_en    <= 1'b0;
      rd_data        <= '0;
    end else begin
      state          <= next_state;
      mem_chip_en    <= strobe_next;
      mem_read_write <= write_next;
      if (state == S_IDLE && req_valid) begin
        addr <= req_addr;
        cnt  <= req_len;
      end else if (advance && !last_beat) begin
        cnt  <= cnt - 1'b1;
        addr <= addr + 1'b1;
      end
      if (state == S_WR_WAIT && wr_valid) mem_data_in <= wr_data;
      if (state == S_RD_STROBE) rd_data <= mem_data_out;
    end
  end

`ifdef MEM_ACC_WRITE_VERIFY_EN
  logic verify_err_q;

  // Sticky until reset; compares the read-back against the data just written
  always_ff @(posedge clk) begin
    if (rst) begin
      verify_err_q <= 1'b0;
    end else if (state == S_VF_STROBE && mem_data_out != mem_data_in) begin
      verify_err_q <= 1'b1;
    end
  end

  assign verify_err = verify_err_q;
`else
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a combinational-read SRAM model.
// Honours MEM_ACC_WRITE_VERIFY_EN for the expected verify flag and write beat period.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       busy, done, verify_err;
  logic [7:0] mem_address, mem_data_in, mem_data_out;
  logic       mem_read_write, mem_chip_en;

  logic [7:0] mem [256];
  logic       stuck0;
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;
  logic [8:0] ce_log [$];
  int         done_count = 0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

`ifdef MEM_ACC_WRITE_VERIFY_EN
  localparam int WR_PERIOD = 3;
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam int WR_PERIOD = 2;
  localparam bit VERIFY_ON = 1'b0;
`endif

  mem_access_ctrl #(.AW(8), .DW(8), .LENW(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .verify_err(verify_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_read_write(mem_read_write), .mem_chip_en(mem_chip_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_chip_en && mem_read_write) mem[mem_address] <= mem_data_in;
  end

  assign mem_data_out = stuck0 ? (mem[mem_address] & 8'hFE) : mem[mem_address];

  always @(negedge clk) begin
    if (mem_chip_en) ce_log.push_back({mem_read_write, mem_address});
    if (done) done_count++;
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic start_req(input bit w, input logic [7:0] a, input logic [3:0] len, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      req_valid = 1'b1; req_write = w; req_addr = a; req_len = len;
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic send_beat(input logic [7:0] d, output bit ok, output int t);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      wr_valid = 1'b1; wr_data = d; t = cyc;
      @(negedge clk);
      wr_valid = 1'b0;
    end
  endtask

  task automatic get_beat(output logic [7:0] d, output bit ok);
    ok = 1'b0; d = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      d = rd_data; rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got=%b want=1", req_ready); end
    checks++;
    if ({busy, done, rd_valid, wr_ready} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_status got=%b want=0000", {busy, done, rd_valid, wr_ready});
    end
    checks++;
    if ({mem_chip_en, mem_read_write, verify_err} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_mem_ctl got=%b want=000", {mem_chip_en, mem_read_write, verify_err});
    end
  endtask

  task automatic test_single;
    bit ok, ok2; int t; int ce0, dn0; logic [7:0] d;
    ce0 = ce_log.size(); dn0 = done_count;
    start_req(1'b1, 8'h10, 4'd0, ok);
    send_beat(8'hA5, ok2, t);
    checks++;
    if (!(ok && ok2)) begin errors++; $display("[TB] FAIL single_wr_handshake got=%b%b want=11", ok, ok2); end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL single_wr_done got=timeout want=pulse"); end
    checks++;
    if (ce_log.size() - ce0 !== 1 + int'(VERIFY_ON)) begin
      errors++; $display("[TB] FAIL single_wr_strobes got=%0d want=%0d", ce_log.size() - ce0, 1 + int'(VERIFY_ON));
    end
    checks++;
    if (done_count - dn0 !== 1) begin errors++; $display("[TB] FAIL single_wr_done_count got=%0d want=1", done_count - dn0); end
    checks++;
    if (ce_log[ce0] !== 9'h110) begin errors++; $display("[TB] FAIL single_wr_strobe got=%h want=110", ce_log[ce0]); end

    ce0 = ce_log.size(); dn0 = done_count;
    start_req(1'b0, 8'h10, 4'd0, ok);
    get_beat(d, ok2);
    checks++;
    if (!(ok && ok2) || d !== 8'hA5) begin errors++; $display("[TB] FAIL single_rd_data got=%h want=a5", d); end
    wait_done(ok);
    checks++;
    if (!ok || done_count - dn0 !== 1) begin errors++; $display("[TB] FAIL single_rd_done got=%0d want=1", done_count - dn0); end
    checks++;
    if (ce_log.size() - ce0 !== 1 || ce_log[ce0] !== 9'h010) begin
      errors++; $display("[TB] FAIL single_rd_strobe got=%0d want=1", ce_log.size() - ce0);
    end
  endtask

  task automatic test_burst_wrap;
    bit ok, okb; int t[4]; int ce0, dn0, n; logic [7:0] d;
    logic [7:0] wdata [4];
    logic [7:0] waddr [4];
    wdata = '{8'h11, 8'h22, 8'h33, 8'h44};
    waddr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    ce0 = ce_log.size(); dn0 = done_count;
    start_req(1'b1, 8'hFE, 4'd3, ok);
    for (int i = 0; i < 4; i++) begin
      send_beat(wdata[i], okb, t[i]);
      ok = ok && okb;
    end
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL burst_wr_handshake got=timeout want=4 beats"); end
    checks++;
    if (t[1] - t[0] !== WR_PERIOD || t[3] - t[2] !== WR_PERIOD) begin
      errors++; $display("[TB] FAIL burst_wr_period got=%0d want=%0d", t[1] - t[0], WR_PERIOD);
    end
    wait_done(ok);
    checks++;
    if (!ok || done_count - dn0 !== 1) begin errors++; $display("[TB] FAIL burst_wr_done got=%0d want=1", done_count - dn0); end
    n = 0;
    for (int i = ce0; i < ce_log.size(); i++) begin
      if (ce_log[i][8]) begin
        checks++;
        if (n > 3 || ce_log[i][7:0] !== waddr[n & 3]) begin
          errors++; $display("[TB] FAIL burst_wr_addr%0d got=%h want=%h", n, ce_log[i][7:0], waddr[n & 3]);
        end
        n++;
      end
    end
    checks++;
    if (n !== 4) begin errors++; $display("[TB] FAIL burst_wr_strobes got=%0d want=4", n); end

    dn0 = done_count;
    start_req(1'b0, 8'hFE, 4'd3, ok);
    for (int i = 0; i < 4; i++) begin
      get_beat(d, okb);
      checks++;
      if (!(ok && okb) || d !== wdata[i]) begin
        errors++; $display("[TB] FAIL burst_rd_beat%0d got=%h want=%h", i, d, wdata[i]);
      end
    end
    wait_done(ok);
    checks++;
    if (!ok || done_count - dn0 !== 1) begin errors++; $display("[TB] FAIL burst_rd_done got=%0d want=1", done_count - dn0); end
  endtask

  task automatic test_rd_stall;
    bit ok, okb; int ce0; logic [7:0] d;
    ce0 = ce_log.size();
    start_req(1'b0, 8'hFE, 4'd1, ok);
    okb = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid === 1'b1) begin okb = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!(ok && okb)) begin errors++; $display("[TB] FAIL stall_first_valid got=timeout want=rd_valid"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rd_valid, mem_chip_en} !== 2'b10 || rd_data !== 8'h11) begin
        errors++; $display("[TB] FAIL stall_hold%0d got=%b/%h want=10/11", i, {rd_valid, mem_chip_en}, rd_data);
      end
      @(negedge clk);
    end
    get_beat(d, okb);
    checks++;
    if (!okb || d !== 8'h11) begin errors++; $display("[TB] FAIL stall_beat0 got=%h want=11", d); end
    get_beat(d, okb);
    checks++;
    if (!okb || d !== 8'h22) begin errors++; $display("[TB] FAIL stall_beat1 got=%h want=22", d); end
    wait_done(ok);
    checks++;
    if (!ok || ce_log.size() - ce0 !== 2) begin
      errors++; $display("[TB] FAIL stall_strobes got=%0d want=2", ce_log.size() - ce0);
    end
  endtask

  task automatic test_reset_mid_burst;
    bit ok, okb; int t; int dn0;
    for (int i = 0; i < 4; i++) preload(8'h40 + 8'(i), 8'hEE);
    dn0 = done_count;
    start_req(1'b1, 8'h40, 4'd3, ok);
    send_beat(8'hA1, okb, t);
    ok = ok && okb;
    send_beat(8'hA2, okb, t);
    ok = ok && okb;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL abort_handshake got=timeout want=2 beats"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req_ready, busy, mem_chip_en, done} !== 4'b1000) begin
      errors++; $display("[TB] FAIL abort_idle got=%b want=1000", {req_ready, busy, mem_chip_en, done});
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (done_count !== dn0) begin errors++; $display("[TB] FAIL abort_no_done got=%0d want=%0d", done_count - dn0, 0); end
    checks++;
    if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'hA1A2EEEE) begin
      errors++; $display("[TB] FAIL abort_mem got=%h%h%h%h want=a1a2eeee", mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
    end
  endtask

  task automatic test_verify;
    bit ok, okb; int t0, t1;
    stuck0 = 1'b1;
    start_req(1'b1, 8'h20, 4'd1, ok);
    send_beat(8'h01, okb, t0);
    ok = ok && okb;
    send_beat(8'h03, okb, t1);
    ok = ok && okb;
    wait_done(okb);
    checks++;
    if (!(ok && okb)) begin errors++; $display("[TB] FAIL verify_burst got=timeout want=done"); end
    checks++;
    if (t1 - t0 !== WR_PERIOD) begin errors++; $display("[TB] FAIL verify_period got=%0d want=%0d", t1 - t0, WR_PERIOD); end
    checks++;
    if (verify_err !== VERIFY_ON) begin errors++; $display("[TB] FAIL verify_flag got=%b want=%b", verify_err, VERIFY_ON); end
    stuck0 = 1'b0;
    start_req(1'b1, 8'h21, 4'd0, ok);
    send_beat(8'h02, okb, t0);
    wait_done(okb);
    repeat (3) @(negedge clk);
    checks++;
    if (verify_err !== VERIFY_ON) begin errors++; $display("[TB] FAIL verify_sticky got=%b want=%b", verify_err, VERIFY_ON); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (verify_err !== 1'b0) begin errors++; $display("[TB] FAIL verify_clear got=%b want=0", verify_err); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    stuck0 = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    $display("[TB] start, write-verify=%0d", VERIFY_ON);
    test_reset();
    test_single();
    test_burst_wrap();
    test_rd_stall();
    test_reset_mid_burst();
    test_verify();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
